// File: rtl/tm1638_chain_driver.sv
// TM1638 daisy-chain refresh serialiser feeding a downstream SPI word FIFO.
// Optional: define TM1638_SKIP_UNCHANGED_EN to skip boards whose image is unchanged.
module tm1638_chain_driver #(
    parameter int NUM_BOARDS = 4,
    parameter int BOARD_W    = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1,
    parameter int DATA_W     = 10 + BOARD_W
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic [NUM_BOARDS*64-1:0]  i_Segments,
    input  logic [NUM_BOARDS*8-1:0]   i_Leds,
    input  logic [2:0]                i_Brightness,
    input  logic                      i_Display_On,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic                      i_SPI_FIFO_Full,
    output logic [DATA_W-1:0]         o_Data,
    output logic                      o_Write,
    output logic [2:0]                o_Diag_State,
    output logic [BOARD_W-1:0]        o_Diag_Board,
    output logic [3:0]                o_Diag_Grid
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD_DATA = 3'd1,
        S_CMD_ADDR = 3'd2,
        S_DATA     = 3'd3,
        S_CMD_CTRL = 3'd4
    } state_t;

    state_t                   r_State;
    logic                     r_Ready;
    logic                     r_Pending;
    logic [DATA_W-1:0]        r_Data;
    logic [BOARD_W-1:0]       r_Board;
    logic [3:0]               r_Grid;

    logic [NUM_BOARDS*64-1:0] r_Seg;
    logic [NUM_BOARDS*8-1:0]  r_Led;
    logic [2:0]               r_Bri;
    logic                     r_On;

    logic                     w_Accept;
    logic                     w_Write;
    logic [3:0]               w_Addr;
    logic [7:0]               w_Byte;
    logic [NUM_BOARDS-1:0]    w_Send_Mask;
    logic [NUM_BOARDS-1:0]    w_Run_Mask;
    logic                     w_First_Ok;
    logic [BOARD_W-1:0]       w_First;
    logic                     w_Next_Ok;
    logic [BOARD_W-1:0]       w_Next;

    assign w_Accept     = i_Valid & r_Ready;
    assign w_Write      = r_Pending & ~i_SPI_FIFO_Full;

    assign o_Ready      = r_Ready;
    assign o_Write      = w_Write;
    assign o_Data       = r_Data;
    assign o_Diag_State = r_State;
    assign o_Diag_Board = r_Board;
    assign o_Diag_Grid  = r_Grid;

    function automatic logic [DATA_W-1:0] mk_word(
        input logic [BOARD_W-1:0] b,
        input logic [1:0]         f,
        input logic [7:0]         d
    );
        mk_word = {b, f, d};
    endfunction

`ifdef TM1638_SKIP_UNCHANGED_EN
    logic [75:0]           r_Hist [NUM_BOARDS];
    logic [NUM_BOARDS-1:0] r_Mask;

    // A board is sent only if its image or control byte differs from history
    always_comb begin
        w_Send_Mask = '0;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            w_Send_Mask[b] = r_Hist[b] != {i_Display_On, i_Brightness,
                                           i_Leds[b*8 +: 8],
                                           i_Segments[b*64 +: 64]};
        end
    end

    assign w_Run_Mask = r_Mask;

    // History tracks what the accepted pass delivers; cleared to ones on reset
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int b = 0; b < NUM_BOARDS; b++) r_Hist[b] <= '1;
            r_Mask <= '0;
        end else if (w_Accept) begin
            for (int b = 0; b < NUM_BOARDS; b++) begin
                r_Hist[b] <= {i_Display_On, i_Brightness,
                              i_Leds[b*8 +: 8], i_Segments[b*64 +: 64]};
            end
            r_Mask <= w_Send_Mask;
        end
    end
`else
    assign w_Send_Mask = '1;
    assign w_Run_Mask  = '1;
`endif

    // Lowest board to send on accept, and next board after the current one
    always_comb begin
        w_First_Ok = 1'b0;
        w_First    = '0;
        w_Next_Ok  = 1'b0;
        w_Next     = '0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (w_Send_Mask[i]) begin
                w_First_Ok = 1'b1;
                w_First    = BOARD_W'(i);
            end
            if (w_Run_Mask[i] && (i > int'(r_Board))) begin
                w_Next_Ok = 1'b1;
                w_Next    = BOARD_W'(i);
            end
        end
    end

    assign w_Addr = (r_State == S_DATA) ? r_Grid + 4'd1 : 4'd0;

    // Display RAM byte for the next address: even = segments, odd = LED bit
    always_comb begin
        w_Byte = 8'h00;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            for (int g = 0; g < 8; g++) begin
                if (r_Board == BOARD_W'(b) && w_Addr[3:1] == 3'(g)) begin
                    w_Byte = w_Addr[0] ? {7'b0, r_Led[b*8 + g]}
                                       : r_Seg[b*64 + g*8 +: 8];
                end
            end
        end
    end

    // Shadow copy of the image, taken only on an accepted request
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Seg <= '0;
            r_Led <= '0;
            r_Bri <= '0;
            r_On  <= 1'b0;
        end else if (w_Accept) begin
            r_Seg <= i_Segments;
            r_Led <= i_Leds;
            r_Bri <= i_Brightness;
            r_On  <= i_Display_On;
        end
    end

    // Sequencer: the held word advances only on the cycle it is written
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State   <= S_IDLE;
            r_Ready   <= 1'b1;
            r_Pending <= 1'b0;
            r_Data    <= '0;
            r_Board   <= '0;
            r_Grid    <= '0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (w_Accept && w_First_Ok) begin
                        r_State   <= S_CMD_DATA;
                        r_Ready   <= 1'b0;
                        r_Pending <= 1'b1;
                        r_Board   <= w_First;
                        r_Data    <= mk_word(w_First, 2'b11, 8'h40);
                    end
                end
                S_CMD_DATA: begin
                    if (w_Write) begin
                        r_State <= S_CMD_ADDR;
                        r_Data  <= mk_word(r_Board, 2'b01, 8'hC0);
                    end
                end
                S_CMD_ADDR: begin
                    if (w_Write) begin
                        r_State <= S_DATA;
                        r_Grid  <= 4'd0;
                        r_Data  <= mk_word(r_Board, 2'b00, w_Byte);
                    end
                end
                S_DATA: begin
                    if (w_Write) begin
                        if (r_Grid == 4'd15) begin
                            r_State <= S_CMD_CTRL;
                            r_Grid  <= 4'd0;
                            r_Data  <= mk_word(r_Board, 2'b11,
                                               {4'b1000, r_On, r_Bri});
                        end else begin
                            r_Grid <= w_Addr;
                            r_Data <= mk_word(r_Board,
                                              (w_Addr == 4'd15) ? 2'b10 : 2'b00,
                                              w_Byte);
                        end
                    end
                end
                S_CMD_CTRL: begin
                    if (w_Write) begin
                        if (w_Next_Ok) begin
                            r_State <= S_CMD_DATA;
                            r_Board <= w_Next;
                            r_Data  <= mk_word(w_Next, 2'b11, 8'h40);
                        end else begin
                            r_State   <= S_IDLE;
                            r_Ready   <= 1'b1;
                            r_Pending <= 1'b0;
                            r_Board   <= '0;
                        end
                    end
                end
                default: begin
                    r_State   <= S_IDLE;
                    r_Ready   <= 1'b1;
                    r_Pending <= 1'b0;
                    r_Board   <= '0;
                    r_Grid    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_chain_driver.sv
// Randomised self-checking bench for tm1638_chain_driver (two boards).
// Expected word streams come from a queue-based model of the refresh rules.
module tb_tm1638_chain_driver;

    localparam int NB = 2;
    localparam int BW = 1;
    localparam int DW = 10 + BW;

    logic              clk;
    logic              rst_n;
    logic [NB*64-1:0]  seg;
    logic [NB*8-1:0]   led;
    logic [2:0]        bri;
    logic              on;
    logic              valid;
    logic              ready;
    logic              full;
    logic [DW-1:0]     data;
    logic              wr;
    logic [2:0]        dstate;
    logic [BW-1:0]     dboard;
    logic [3:0]        dgrid;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rand_full = 0;

    logic [DW-1:0] obs_q[$];
    logic [3:0]    obs_grid_q[$];
    logic [BW-1:0] obs_brd_q[$];
    int            obs_cyc_q[$];
    logic [DW-1:0] exp_q[$];
    logic [3:0]    exp_grid_q[$];

`ifdef TM1638_SKIP_UNCHANGED_EN
    logic [75:0] m_hist [NB];
`endif

    tm1638_chain_driver #(.NUM_BOARDS(NB)) dut (
        .i_Clk           (clk),
        .i_Rst_n         (rst_n),
        .i_Segments      (seg),
        .i_Leds          (led),
        .i_Brightness    (bri),
        .i_Display_On    (on),
        .i_Valid         (valid),
        .o_Ready         (ready),
        .i_SPI_FIFO_Full (full),
        .o_Data          (data),
        .o_Write         (wr),
        .o_Diag_State    (dstate),
        .o_Diag_Board    (dboard),
        .o_Diag_Grid     (dgrid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Collect every word the FIFO actually takes
    always @(negedge clk) begin
        if (wr) begin
            obs_q.push_back(data);
            obs_grid_q.push_back(dgrid);
            obs_brd_q.push_back(dboard);
            obs_cyc_q.push_back(cyc);
            check("wr_while_full", full, 0);
        end
    end

    // Random FIFO back-pressure, 20..120 ns per level
    always begin
        if (rand_full) begin
            repeat ($urandom_range(2, 12)) @(posedge clk);
            #1;
            if (rand_full) full = ~full;
        end else begin
            @(posedge clk);
        end
    end

    task automatic push_exp(input logic [DW-1:0] w, input logic [3:0] g);
        exp_q.push_back(w);
        exp_grid_q.push_back(g);
    endtask

    // Reference: words one accepted image should produce
    task automatic model_pass();
        logic [NB*64-1:0] st;
        logic [NB*8-1:0]  lt;
        logic [7:0]       byt;
        logic [1:0]       frm;
        logic [BW-1:0]    bb;
        bit               send;
        for (int b = 0; b < NB; b++) begin
            send = 1;
`ifdef TM1638_SKIP_UNCHANGED_EN
            begin
                logic [75:0] img;
                st  = seg >> (b * 64);
                lt  = led >> (b * 8);
                img = {on, bri, lt[7:0], st[63:0]};
                send = (img != m_hist[b]);
                m_hist[b] = img;
            end
`endif
            if (send) begin
                bb = BW'(b);
                push_exp({bb, 2'b11, 8'h40}, 4'd0);
                push_exp({bb, 2'b01, 8'hC0}, 4'd0);
                for (int a = 0; a < 16; a++) begin
                    if (a % 2 == 0) begin
                        st  = seg >> (b * 64 + (a / 2) * 8);
                        byt = st[7:0];
                    end else begin
                        lt  = led >> (b * 8 + a / 2);
                        byt = {7'b0, lt[0]};
                    end
                    frm = (a == 15) ? 2'b10 : 2'b00;
                    push_exp({bb, frm, byt}, 4'(a));
                end
                push_exp({bb, 2'b11, 4'b1000, on, bri}, 4'd0);
            end
        end
    endtask

    task automatic send_image();
        @(negedge clk);
        #1;
        check("ready_before_accept", ready, 1);
        check("idle_no_write", wr, 0);
        valid = 1;
        model_pass();
        @(posedge clk);
        #1;
        valid = 0;
    endtask

    task automatic wait_done(input int limit);
        bit done = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (ready) begin
                done = 1;
                break;
            end
        end
        check("pass_timeout", done, 1);
        check("ready_after_last", obs_q.size(), exp_q.size());
    endtask

    task automatic clear_q();
        obs_q.delete();
        obs_grid_q.delete();
        obs_brd_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        exp_grid_q.delete();
    endtask

    task automatic compare_pass(input string tag);
        logic [DW-1:0] ew;
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < obs_q.size()) begin
                ew = exp_q[k];
                check({tag, "_word"}, obs_q[k], ew);
                check({tag, "_grid"}, obs_grid_q[k], exp_grid_q[k]);
                check({tag, "_board"}, obs_brd_q[k], ew[DW-1:10]);
            end
        end
        clear_q();
    endtask

    task automatic stop_full();
        @(negedge clk);
        rand_full = 0;
        full = 0;
    endtask

    task automatic rand_image();
        seg = {$urandom(), $urandom(), $urandom(), $urandom()};
        led = 16'($urandom());
        bri = 3'($urandom());
        on  = 1'($urandom());
    endtask

    initial begin
        bit seen;
        rst_n = 0;
        seg   = '0;
        led   = '0;
        bri   = '0;
        on    = 0;
        valid = 0;
        full  = 0;
`ifdef TM1638_SKIP_UNCHANGED_EN
        for (int b = 0; b < NB; b++) m_hist[b] = '1;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_data", data, 0);
        check("rst_write", wr, 0);
        check("rst_state", dstate, 0);
        check("rst_board", dboard, 0);
        check("rst_grid", dgrid, 0);
        @(negedge clk);
        rst_n = 1;

        // Directed image, no back-pressure
        seg = '0;
        for (int g = 0; g < 8; g++) begin
            seg = seg | ((NB*64)'(32'h10 + g) << (g * 8));
        end
        seg[127:64] = {$urandom(), $urandom()};
        led = {8'($urandom()), 8'hA5};
        bri = 3'd5;
        on  = 1;
        send_image();
        check("first_write_latency", wr, 1);
        wait_done(500);
        if (obs_q.size() == 38) begin
            check("w0", obs_q[0], {1'b0, 2'b11, 8'h40});
            check("w1", obs_q[1], {1'b0, 2'b01, 8'hC0});
            check("w2", obs_q[2], {1'b0, 2'b00, 8'h10});
            check("w3", obs_q[3], {1'b0, 2'b00, 8'h01});
            check("w17", obs_q[17], {1'b0, 2'b10, 8'h01});
            check("w18", obs_q[18], {1'b0, 2'b11, 8'h8D});
            check("w19", obs_q[19], {1'b1, 2'b11, 8'h40});
            check("back_to_back", obs_cyc_q[37] - obs_cyc_q[0], 37);
        end
        check("idle_state", dstate, 0);
        compare_pass("directed");

        // Same image under random back-pressure
        rand_full = 1;
        send_image();
        wait_done(3000);
        stop_full();
        compare_pass("full_toggle");

        // Random images; a second request mid-pass must be ignored
        for (int it = 0; it < 4; it++) begin
            rand_image();
            rand_full = (it % 2 == 0);
            send_image();
            seen = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                #1;
                if (obs_q.size() >= 5) begin
                    seen = 1;
                    break;
                end
            end
            check("midpass_timeout", seen, 1);
            check("busy_ready", ready, 0);
            valid = 1;
            seg = ~seg;
            led = ~led;
            bri = ~bri;
            @(posedge clk);
            #1;
            valid = 0;
            check("busy_ready_after", ready, 0);
            wait_done(3000);
            stop_full();
            compare_pass("random");
        end

        // Display off, minimum brightness
        rand_image();
        bri = 3'd0;
        on  = 0;
        send_image();
        wait_done(500);
        foreach (obs_q[k]) begin
            if (obs_q[k][9:8] == 2'b11 && obs_q[k][7:0] != 8'h40) begin
                check("ctrl_off", obs_q[k][7:0], 8'h80);
            end
        end
        compare_pass("display_off");

        // Reset after seven writes aborts the pass
        rand_image();
        send_image();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= 7) begin
                seen = 1;
                break;
            end
        end
        check("rst_wait_timeout", seen, 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("abort_write", wr, 0);
        check("abort_ready", ready, 1);
        check("abort_state", dstate, 0);
        repeat (3) @(negedge clk);
        #1;
        check("abort_count", obs_q.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < obs_q.size()) check("abort_prefix", obs_q[k], exp_q[k]);
        end
        clear_q();
`ifdef TM1638_SKIP_UNCHANGED_EN
        for (int b = 0; b < NB; b++) m_hist[b] = '1;
`endif
        @(negedge clk);
        rst_n = 1;
        #1;
        check("release_ready", ready, 1);
        rand_image();
        send_image();
        wait_done(500);
        if (obs_q.size() > 0) check("restart_board0", obs_q[0], {1'b0, 2'b11, 8'h40});
        compare_pass("after_reset");

`ifdef TM1638_SKIP_UNCHANGED_EN
        // Only board 1 changes between two passes
        rand_image();
        send_image();
        wait_done(500);
        compare_pass("skip_first");
        led[8] = ~led[8];
        send_image();
        wait_done(500);
        check("skip_len", obs_q.size(), 19);
        foreach (obs_q[k]) check("skip_board", obs_q[k][DW-1:10], 1);
        compare_pass("skip_second");
        send_image();
        wait_done(20);
        compare_pass("skip_none");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
